// File: rtl/wca_up_interpolator_if.sv
// wca_up_interpolator_if: host-side complex sample stream into the TX interpolator.
interface wca_up_interpolator_if;
    logic [31:0] iq_in;
    logic        iq_valid;
    logic        iq_ready;
    modport master (output iq_in, iq_valid, input iq_ready);
    modport slave  (input iq_in, iq_valid, output iq_ready);
endinterface

// File: rtl/wca_up_interpolator.sv
// wca_up_interpolator: 2^k linear interpolator from 16-bit host IQ to 12-bit DAC IQ, one output per strobe.
module wca_up_interpolator #(
    parameter int RATE_LOG2_MAX = 7,
    parameter int OUT_WIDTH     = 12
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable_i,
    input  logic                   aclr_i,
    input  logic [2:0]             rate_log2_i,
    input  logic [1:0]             cfgflags_i,
    wca_up_interpolator_if.slave   iq_if,
    input  logic                   dstrobe_i,
    output logic [2*OUT_WIDTH-1:0] iq_o,
    output logic                   dstrobe_o,
    output logic                   underflow_o
);
    localparam int PW = RATE_LOG2_MAX;
    localparam int AW = 17 + RATE_LOG2_MAX;
    logic [31:0]   mem_q [2];
    logic          wr_q, rd_q, rdy_q, ds_q, uf_q;
    logic [1:0]    cnt_q, cnt_d;
    logic [PW-1:0] p_q, p_d, mask;
    logic [2:0]    k_q, k_d;
    logic          clr, act, byp, seg, empty, pop, push, unused_cfg;
    assign clr        = reset | aclr_i;
    assign act        = dstrobe_i & enable_i;
    assign byp        = cfgflags_i[0];
    assign unused_cfg = cfgflags_i[1];
    assign seg        = act & (byp | (p_q == '0));
    assign empty      = cnt_q == 2'd0;
    assign pop        = seg & !empty;
    assign push       = iq_if.iq_valid & rdy_q;
    // The new rate is latched at a segment start and immediately sizes that segment.
    always_comb begin
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        k_d   = (seg && !byp) ? rate_log2_i : k_q;
        mask  = (PW'(1) << k_d) - PW'(1);
        p_d   = !act ? p_q : (byp || p_q == mask) ? '0 : p_q + PW'(1);
    end
    always_ff @(posedge clock) begin
        if (clr) begin
            mem_q <= '{default: '0};
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
            rdy_q <= 1'b1;
            p_q   <= '0;
            k_q   <= '0;
            ds_q  <= 1'b0;
            uf_q  <= 1'b0;
        end else begin
            if (push) mem_q[wr_q] <= iq_if.iq_in;
            wr_q  <= wr_q ^ push;
            rd_q  <= rd_q ^ pop;
            cnt_q <= cnt_d;
            rdy_q <= cnt_d != 2'd2;
            p_q   <= p_d;
            k_q   <= k_d;
            ds_q  <= act;
            uf_q  <= uf_q | (seg & empty);
        end
    end
    assign iq_if.iq_ready = rdy_q;
    assign dstrobe_o      = ds_q;
    assign underflow_o    = uf_q;
    // Lane 0 carries I, lane 1 carries Q; both follow identical rules.
    for (genvar g = 0; g < 2; g++) begin : lane
        logic signed [15:0]   head, curr_q, curr_d;
        logic signed [16:0]   delta_q, delta_d;
        logic signed [AW-1:0] acc_q, acc_d, co, sum, y, r;
        logic [11:0]          out_q, out_d;
        always_comb begin
            head    = mem_q[rd_q][16*g +: 16];
            curr_d  = pop ? head : curr_q;
            co      = curr_q;
            sum     = acc_q + AW'(delta_q);
            delta_d = (seg && !byp) ? 17'(curr_d) - 17'(curr_q) : delta_q;
            acc_d   = (seg && !byp) ? co <<< k_d : (act && !seg) ? sum : acc_q;
            y       = seg ? (byp ? AW'(curr_d) : co) : sum >>> k_q;
            r       = (y + AW'(8)) >>> 4;
            out_d   = r > AW'(2047) ? 12'h7ff : r < -AW'(2048) ? 12'h800 : r[11:0];
        end
        always_ff @(posedge clock) begin
            if (clr) begin
                curr_q  <= '0;
                delta_q <= '0;
                acc_q   <= '0;
                out_q   <= '0;
            end else begin
                curr_q  <= curr_d;
                delta_q <= delta_d;
                acc_q   <= acc_d;
                if (act) out_q <= out_d;
            end
        end
        assign iq_o[12*g +: 12] = out_q;
    end
endmodule

// File: tb/tb_wca_up_interpolator.sv
// tb_wca_up_interpolator: directed scenario bench for the TX up-interpolator.
module tb_wca_up_interpolator;
    logic        clk = 1'b0;
    logic        rst, enable, aclr, ds;
    logic [2:0]  rate;
    logic [1:0]  cfg;
    logic [23:0] iq_o;
    logic        ds_o, uf;
    int          total = 0;
    int          bad = 0;

    wca_up_interpolator_if bus();

    wca_up_interpolator dut (
        .clock(clk), .reset(rst), .enable_i(enable), .aclr_i(aclr),
        .rate_log2_i(rate), .cfgflags_i(cfg), .iq_if(bus), .dstrobe_i(ds),
        .iq_o(iq_o), .dstrobe_o(ds_o), .underflow_o(uf)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.iq_valid = 1'b0;
        ds = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic strobe();
        @(negedge clk);
        ds = 1'b1;
        @(negedge clk);
        ds = 1'b0;
    endtask

    task automatic push(input int i, input int q);
        int n = 0;
        logic [15:0] ti, tq;
        ti = 16'(i);
        tq = 16'(q);
        @(negedge clk);
        bus.iq_in = {tq, ti};
        bus.iq_valid = 1'b1;
        while (bus.iq_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.iq_ready !== 1'b1) begin
            bad++;
            $display("FAIL push_wait: iq_ready=%b after %0d cycles, want 1", bus.iq_ready, n);
        end
        @(negedge clk);
        bus.iq_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        total++;
        if (iq_o !== 24'h0 || ds_o !== 1'b0 || uf !== 1'b0 || bus.iq_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset: iq=%h ds=%b uf=%b rdy=%b, want 000000 0 0 1", iq_o, ds_o, uf, bus.iq_ready);
        end
    endtask

    task automatic test_ramp();
        int e[12] = '{0, 0, 0, 0, 0, 16, 32, 48, 64, 80, 96, 112};
        do_reset();
        rate = 3'd2;
        cfg = 2'd0;
        push(0, 0);
        push(1024, -1024);
        for (int n = 0; n < 12; n++) begin
            strobe();
            total++;
            if (ds_o !== 1'b1 || $signed(iq_o[11:0]) !== e[n] || $signed(iq_o[23:12]) !== -e[n]) begin
                bad++;
                $display("FAIL ramp[%0d]: ds=%b I=%0d Q=%0d, want 1 %0d %0d", n, ds_o,
                         $signed(iq_o[11:0]), $signed(iq_o[23:12]), e[n], -e[n]);
            end
            @(negedge clk);
            total++;
            if (ds_o !== 1'b0 || $signed(iq_o[11:0]) !== e[n]) begin
                bad++;
                $display("FAIL ramp_hold[%0d]: ds=%b I=%0d, want 0 %0d", n, ds_o, $signed(iq_o[11:0]), e[n]);
            end
            if (n == 0) push(2048, -2048);
            else repeat (2) @(negedge clk);
        end
        total++;
        if (uf !== 1'b0) begin
            bad++;
            $display("FAIL ramp_uf: underflow=%b, want 0", uf);
        end
    endtask

    task automatic test_saturation();
        int si[4] = '{32767, -32768, 7, -8};
        int sq[4] = '{-32768, 32767, -8, 7};
        int ei[4] = '{2047, -2048, 0, 0};
        int eq[4] = '{-2048, 2047, 0, 0};
        do_reset();
        rate = 3'd3;
        cfg = 2'd1;
        push(si[0], sq[0]);
        push(si[1], sq[1]);
        for (int n = 0; n < 4; n++) begin
            strobe();
            total++;
            if (ds_o !== 1'b1 || $signed(iq_o[11:0]) !== ei[n] || $signed(iq_o[23:12]) !== eq[n]) begin
                bad++;
                $display("FAIL sat[%0d]: ds=%b I=%0d Q=%0d, want 1 %0d %0d", n, ds_o,
                         $signed(iq_o[11:0]), $signed(iq_o[23:12]), ei[n], eq[n]);
            end
            if (n < 2) push(si[n+2], sq[n+2]);
        end
        total++;
        if (uf !== 1'b0) begin
            bad++;
            $display("FAIL sat_uf: underflow=%b, want 0", uf);
        end
        cfg = 2'd0;
    endtask

    task automatic test_underflow();
        int e[6] = '{0, 5, 10, 10, 10, 10};
        do_reset();
        rate = 3'd1;
        cfg = 2'd0;
        push(160, -160);
        for (int n = 0; n < 6; n++) begin
            strobe();
            total++;
            if ($signed(iq_o[11:0]) !== e[n] || $signed(iq_o[23:12]) !== -e[n] || uf !== (n >= 2)) begin
                bad++;
                $display("FAIL underflow[%0d]: I=%0d Q=%0d uf=%b, want %0d %0d %b", n,
                         $signed(iq_o[11:0]), $signed(iq_o[23:12]), uf, e[n], -e[n], n >= 2);
            end
        end
        @(negedge clk);
        aclr = 1'b1;
        @(negedge clk);
        aclr = 1'b0;
        total++;
        if (uf !== 1'b0 || iq_o !== 24'h0 || ds_o !== 1'b0 || bus.iq_ready !== 1'b1) begin
            bad++;
            $display("FAIL aclr: uf=%b iq=%h ds=%b rdy=%b, want 0 000000 0 1", uf, iq_o, ds_o, bus.iq_ready);
        end
    endtask

    task automatic test_fifo_flow();
        int s[3] = '{160, 320, 480};
        int e[3] = '{10, 20, 30};
        int n = 0;
        logic rdy;
        do_reset();
        rate = 3'd0;
        cfg = 2'd0;
        bus.iq_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.iq_in = {16'(-s[n]), 16'(s[n])};
            rdy = bus.iq_ready;
            @(negedge clk);
            if (rdy) n++;
        end
        total++;
        if (n != 2 || bus.iq_ready !== 1'b0) begin
            bad++;
            $display("FAIL fifo_full: accepted=%0d rdy=%b, want 2 0", n, bus.iq_ready);
        end
        ds = 1'b1;
        @(negedge clk);
        ds = 1'b0;
        total++;
        if (bus.iq_ready !== 1'b1 || ds_o !== 1'b1 || $signed(iq_o[11:0]) !== 0) begin
            bad++;
            $display("FAIL fifo_pop: rdy=%b ds=%b I=%0d, want 1 1 0", bus.iq_ready, ds_o, $signed(iq_o[11:0]));
        end
        @(negedge clk);
        bus.iq_valid = 1'b0;
        total++;
        if (bus.iq_ready !== 1'b0) begin
            bad++;
            $display("FAIL fifo_refill: rdy=%b, want 0", bus.iq_ready);
        end
        for (int k = 0; k < 3; k++) begin
            strobe();
            total++;
            if ($signed(iq_o[11:0]) !== e[k] || $signed(iq_o[23:12]) !== -e[k] || uf !== (k == 2)) begin
                bad++;
                $display("FAIL fifo_drain[%0d]: I=%0d Q=%0d uf=%b, want %0d %0d %b", k,
                         $signed(iq_o[11:0]), $signed(iq_o[23:12]), uf, e[k], -e[k], k == 2);
            end
        end
    endtask

    task automatic test_rate_change();
        int e[12] = '{0, 8, 16, 24, 32, 40, 48, 56, 64, 96, 128, 160};
        do_reset();
        rate = 3'd3;
        cfg = 2'd0;
        push(1024, -1024);
        push(2048, -2048);
        for (int n = 0; n < 12; n++) begin
            if (n == 4) rate = 3'd1;
            strobe();
            total++;
            if ($signed(iq_o[11:0]) !== e[n] || $signed(iq_o[23:12]) !== -e[n]) begin
                bad++;
                $display("FAIL rate[%0d]: I=%0d Q=%0d, want %0d %0d", n,
                         $signed(iq_o[11:0]), $signed(iq_o[23:12]), e[n], -e[n]);
            end
            if (n == 0) push(3072, -3072);
        end
        total++;
        if (uf !== 1'b0) begin
            bad++;
            $display("FAIL rate_uf: underflow=%b, want 0", uf);
        end
    endtask

    task automatic test_enable_reset();
        int e[6] = '{0, 16, 32, 48, 64, 80};
        do_reset();
        rate = 3'd2;
        cfg = 2'd0;
        push(1024, -1024);
        push(2048, -2048);
        for (int n = 0; n < 6; n++) begin
            if (n == 2) begin
                enable = 1'b0;
                for (int d = 0; d < 2; d++) begin
                    strobe();
                    total++;
                    if (ds_o !== 1'b0 || $signed(iq_o[11:0]) !== 16) begin
                        bad++;
                        $display("FAIL disabled[%0d]: ds=%b I=%0d, want 0 16", d, ds_o, $signed(iq_o[11:0]));
                    end
                end
                enable = 1'b1;
            end
            strobe();
            total++;
            if (ds_o !== 1'b1 || $signed(iq_o[11:0]) !== e[n] || $signed(iq_o[23:12]) !== -e[n]) begin
                bad++;
                $display("FAIL enable[%0d]: ds=%b I=%0d Q=%0d, want 1 %0d %0d", n, ds_o,
                         $signed(iq_o[11:0]), $signed(iq_o[23:12]), e[n], -e[n]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        ds = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ds = 1'b0;
        total++;
        if (ds_o !== 1'b0 || iq_o !== 24'h0 || uf !== 1'b0 || bus.iq_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_strobe: ds=%b iq=%h uf=%b rdy=%b, want 0 000000 0 1", ds_o, iq_o, uf, bus.iq_ready);
        end
        push(1024, -1024);
        for (int n = 0; n < 2; n++) begin
            strobe();
            total++;
            if (ds_o !== 1'b1 || $signed(iq_o[11:0]) !== e[n] || uf !== 1'b0) begin
                bad++;
                $display("FAIL after_reset[%0d]: ds=%b I=%0d uf=%b, want 1 %0d 0", n, ds_o,
                         $signed(iq_o[11:0]), uf, e[n]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        aclr = 1'b0;
        ds = 1'b0;
        rate = 3'd0;
        cfg = 2'd0;
        bus.iq_in = 32'h0;
        bus.iq_valid = 1'b0;
        test_reset();
        test_ramp();
        test_saturation();
        test_underflow();
        test_fifo_flow();
        test_rate_change();
        test_enable_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
